// File: rtl/ipv4_vlg_pkg.sv
// Shared types and helpers for the IPv4 receive parser.
package ipv4_vlg_pkg;

  localparam int IPV4_HDR_LEN = 20;

  // Fixed 20-byte header, byte 0 in the most significant bits.
  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [7:0]  tos;
    logic [15:0] total_len;
    logic [15:0] id;
    logic        flag_rsv;
    logic        flag_df;
    logic        flag_mf;
    logic [12:0] frag_off;
    logic [7:0]  ttl;
    logic [7:0]  proto;
    logic [15:0] cks;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } ipv4_hdr_t;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] id;
    logic [15:0] pld_len;
    logic [7:0]  proto;
    logic [7:0]  ttl;
  } ipv4_meta_t;

  typedef enum logic [2:0] {
    idle_s,
    hdr_s,
    opt_s,
    pld_s,
    skip_s
  } rx_state_t;

  function automatic logic [15:0] hdr_len(input logic [3:0] ihl);
    return {10'd0, ihl, 2'b00};
  endfunction

  function automatic logic hdr_ok(input ipv4_hdr_t h, input logic [15:0] cks_fold,
                                  input logic [31:0] dev_ip);
    return (h.version == 4'd4) && (h.ihl >= 4'd5) &&
           (h.total_len >= hdr_len(h.ihl)) && (cks_fold == 16'hFFFF) &&
           !h.flag_mf && (h.frag_off == 13'd0) &&
           ((h.dst_ip == dev_ip) || (h.dst_ip == 32'hFFFF_FFFF));
  endfunction

endpackage

// File: rtl/ipv4_vlg_cks_acc.sv
// Ones-complement header checksum accumulator fed one byte at a time.
// fold already includes the byte presented this cycle, so the parser can judge on the last byte.
module ipv4_vlg_cks_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        val,
  input  logic [7:0]  dat,
  output logic [15:0] fold
);

  logic [19:0] sum_q;
  logic [19:0] sum_d;
  logic [7:0]  hi_q;
  logic        odd_q;
  logic [16:0] fold1;

  always_comb begin
    sum_d = sum_q;
    if (val && odd_q && !clr)
      sum_d = sum_q + {4'd0, hi_q, dat};
    fold1 = {1'b0, sum_d[15:0]} + {13'd0, sum_d[19:16]};
    fold  = fold1[15:0] + {15'd0, fold1[16]};
  end

  // clr with val starts a new header whose first byte is the high half of word 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      hi_q  <= '0;
      odd_q <= 1'b0;
    end else if (clr) begin
      sum_q <= '0;
      hi_q  <= dat;
      odd_q <= val;
    end else if (val) begin
      if (odd_q) begin
        sum_q <= sum_d;
        odd_q <= 1'b0;
      end else begin
        hi_q  <= dat;
        odd_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ipv4_vlg_rx.sv
// IPv4 receive parser: validates the header, publishes metadata, forwards payload one cycle late.
//
// state  | meaning
// idle_s | waiting for an IPv4 start of frame
// hdr_s  | capturing the fixed 20-byte header
// opt_s  | discarding header option bytes
// pld_s  | forwarding payload bytes up to total_length
// skip_s | dropping bytes until end of frame
module ipv4_vlg_rx
  import ipv4_vlg_pkg::*;
#(
  parameter int    VERBOSE    = 1,
  parameter string DUT_STRING = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dev_ipv4,
  input  logic [7:0]  in_dat,
  input  logic        in_val,
  input  logic        in_sof,
  input  logic        in_eof,
  input  logic        in_ipv4,
  input  logic        in_err,
  output logic [7:0]  out_dat,
  output logic        out_val,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_err,
  output logic        meta_val,
  output logic [31:0] meta_src_ip,
  output logic [31:0] meta_dst_ip,
  output logic [15:0] meta_id,
  output logic [15:0] meta_pld_len,
  output logic [7:0]  meta_proto,
  output logic [7:0]  meta_ttl,
  output logic        busy
);

  rx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  ipv4_hdr_t   hdr_q, hdr_d, hdr_shift, hdr_cur;
  ipv4_meta_t  meta_q, meta_d;
  logic [7:0]  dat_d;
  logic        val_d, sof_d, eof_d, err_d, mval_d;
  logic        cks_clr, cks_val;
  logic [15:0] cks_fold;
  logic [15:0] pld_len;
  logic        last_hdr;

  assign hdr_shift = ipv4_hdr_t'({hdr_q[IPV4_HDR_LEN*8-9:0], in_dat});

  ipv4_vlg_cks_acc u_cks (
    .clk  (clk),
    .rst  (rst),
    .clr  (cks_clr),
    .val  (cks_val),
    .dat  (in_dat),
    .fold (cks_fold)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hdr_d    = hdr_q;
    meta_d   = meta_q;
    dat_d    = out_dat;
    val_d    = 1'b0;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    err_d    = 1'b0;
    mval_d   = 1'b0;
    cks_clr  = 1'b0;
    cks_val  = 1'b0;
    // in hdr_s the header is only complete once the incoming byte is shifted in
    hdr_cur  = (state_q == hdr_s) ? hdr_shift : hdr_q;
    pld_len  = hdr_cur.total_len - hdr_len(hdr_cur.ihl);
    last_hdr = (state_q == hdr_s) ? ((cnt_q == 16'd19) && (hdr_shift.ihl <= 4'd5))
                                  : (cnt_q == hdr_len(hdr_q.ihl) - 16'd1);

    if (in_val && in_sof) begin
      err_d   = (state_q != idle_s);
      state_d = in_ipv4 ? hdr_s : idle_s;
      cnt_d   = 16'd1;
      hdr_d   = hdr_shift;
      cks_clr = 1'b1;
      cks_val = 1'b1;
    end else if (in_val) begin
      case (state_q)
        hdr_s, opt_s: begin
          cnt_d   = cnt_q + 16'd1;
          cks_val = 1'b1;
          if (state_q == hdr_s)
            hdr_d = hdr_shift;
          if (last_hdr) begin
            if (hdr_ok(hdr_cur, cks_fold, dev_ipv4) &&
                !(in_eof && (in_err || (pld_len != 16'd0)))) begin
              mval_d  = 1'b1;
              meta_d  = '{src_ip: hdr_cur.src_ip, dst_ip: hdr_cur.dst_ip, id: hdr_cur.id,
                          pld_len: pld_len, proto: hdr_cur.proto, ttl: hdr_cur.ttl};
              state_d = in_eof ? idle_s : ((pld_len == 16'd0) ? skip_s : pld_s);
            end else begin
              err_d   = 1'b1;
              state_d = in_eof ? idle_s : skip_s;
            end
          end else if (in_eof) begin
            err_d   = 1'b1;
            state_d = idle_s;
          end else if ((state_q == hdr_s) && (cnt_q == 16'd19)) begin
            state_d = opt_s;
          end
        end
        pld_s: begin
          cnt_d = cnt_q + 16'd1;
          dat_d = in_dat;
          val_d = 1'b1;
          sof_d = (cnt_q == hdr_len(hdr_q.ihl));
          if (cnt_q == hdr_q.total_len - 16'd1) begin
            eof_d   = 1'b1;
            err_d   = in_eof && in_err;
            state_d = in_eof ? idle_s : skip_s;
          end else if (in_eof) begin
            err_d   = 1'b1;
            state_d = idle_s;
          end
        end
        skip_s: begin
          if (in_eof) begin
            err_d   = in_err;
            state_d = idle_s;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= idle_s;
      cnt_q    <= '0;
      hdr_q    <= '0;
      meta_q   <= '0;
      out_dat  <= '0;
      out_val  <= 1'b0;
      out_sof  <= 1'b0;
      out_eof  <= 1'b0;
      out_err  <= 1'b0;
      meta_val <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hdr_q    <= hdr_d;
      meta_q   <= meta_d;
      out_dat  <= dat_d;
      out_val  <= val_d;
      out_sof  <= sof_d;
      out_eof  <= eof_d;
      out_err  <= err_d;
      meta_val <= mval_d;
    end
  end

  assign meta_src_ip  = meta_q.src_ip;
  assign meta_dst_ip  = meta_q.dst_ip;
  assign meta_id      = meta_q.id;
  assign meta_pld_len = meta_q.pld_len;
  assign meta_proto   = meta_q.proto;
  assign meta_ttl     = meta_q.ttl;
  assign busy         = (state_q != idle_s);

`ifndef SYNTHESIS
  always @(posedge clk)
    if ((VERBOSE != 0) && meta_val)
      $display("%s ipv4 rx: src %0d.%0d.%0d.%0d dst %0d.%0d.%0d.%0d", DUT_STRING,
               meta_src_ip[31:24], meta_src_ip[23:16], meta_src_ip[15:8], meta_src_ip[7:0],
               meta_dst_ip[31:24], meta_dst_ip[23:16], meta_dst_ip[15:8], meta_dst_ip[7:0]);
`endif

endmodule

// File: tb/tb_ipv4_vlg_rx.sv
// Self-checking bench for ipv4_vlg_rx: generated frames, payload/meta scoreboard, per-scenario tasks.
module tb_ipv4_vlg_rx;

  localparam logic [31:0] DEV = 32'h0A00_0001;
  localparam logic [31:0] SRC = 32'h0A00_0007;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_dat;
  logic        in_val, in_sof, in_eof, in_ipv4, in_err;
  logic [7:0]  out_dat;
  logic        out_val, out_sof, out_eof, out_err, meta_val, busy;
  logic [31:0] meta_src_ip, meta_dst_ip;
  logic [15:0] meta_id, meta_pld_len;
  logic [7:0]  meta_proto, meta_ttl;

  always #5 clk = ~clk;

  ipv4_vlg_rx #(.VERBOSE(1), .DUT_STRING("tb")) dut (
    .clk(clk), .rst(rst), .dev_ipv4(DEV),
    .in_dat(in_dat), .in_val(in_val), .in_sof(in_sof), .in_eof(in_eof),
    .in_ipv4(in_ipv4), .in_err(in_err),
    .out_dat(out_dat), .out_val(out_val), .out_sof(out_sof), .out_eof(out_eof),
    .out_err(out_err), .meta_val(meta_val),
    .meta_src_ip(meta_src_ip), .meta_dst_ip(meta_dst_ip), .meta_id(meta_id),
    .meta_pld_len(meta_pld_len), .meta_proto(meta_proto), .meta_ttl(meta_ttl),
    .busy(busy)
  );

  typedef struct {
    logic [7:0] dat;
    logic       sof;
    logic       eof;
  } pbyte_t;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] id;
    logic [15:0] len;
    logic [7:0]  proto;
    logic [7:0]  ttl;
  } meta_exp_t;

  pbyte_t     exp_q[$];
  meta_exp_t  mexp_q[$];
  logic [7:0] frm[$];
  pbyte_t     pb;
  meta_exp_t  me;

  int n_cmp = 0;
  int n_bad = 0;
  int c_meta = 0, c_val = 0, c_eof = 0, c_err = 0;
  int b_meta, b_val, b_eof, b_err;
  int dm, dv, de, dr;

  // Scoreboard: every payload byte and every meta pulse is checked against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_val) begin
        c_val++;
        if (out_eof) c_eof++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL pld_unexpected got dat=%h sof=%b eof=%b want no byte", out_dat, out_sof, out_eof);
        end else begin
          pb = exp_q.pop_front();
          if ({out_dat, out_sof, out_eof} !== {pb.dat, pb.sof, pb.eof}) begin
            n_bad++;
            $display("FAIL pld_byte got dat=%h sof=%b eof=%b want dat=%h sof=%b eof=%b",
                     out_dat, out_sof, out_eof, pb.dat, pb.sof, pb.eof);
          end
        end
      end
      if (out_err) c_err++;
      if (meta_val) begin
        c_meta++;
        n_cmp++;
        if (mexp_q.size() == 0) begin
          n_bad++;
          $display("FAIL meta_unexpected got len=%0d dst=%h want no meta", meta_pld_len, meta_dst_ip);
        end else begin
          me = mexp_q.pop_front();
          if ({meta_src_ip, meta_dst_ip, meta_id, meta_pld_len, meta_proto, meta_ttl} !==
              {me.src, me.dst, me.id, me.len, me.proto, me.ttl}) begin
            n_bad++;
            $display("FAIL meta_fields got %h/%h/%h/%0d/%0d/%0d want %h/%h/%h/%0d/%0d/%0d",
                     meta_src_ip, meta_dst_ip, meta_id, meta_pld_len, meta_proto, meta_ttl,
                     me.src, me.dst, me.id, me.len, me.proto, me.ttl);
          end
        end
      end
    end
  end

  task automatic build(input logic [31:0] dst, input int ihl, input int plen, input int npad,
                       input logic [15:0] id);
    logic [7:0]  h[60];
    logic [31:0] s;
    int hl, tot;
    hl  = ihl * 4;
    tot = hl + plen;
    for (int i = 0; i < 60; i++) h[i] = 8'h01;
    h[0] = {4'd4, 4'(ihl)};
    h[1] = 8'h00;
    h[2] = 8'(tot >> 8);
    h[3] = 8'(tot);
    h[4] = id[15:8];
    h[5] = id[7:0];
    h[6] = 8'h40;
    h[7] = 8'h00;
    h[8] = 8'd64;
    h[9] = 8'd17;
    h[10] = 8'h00;
    h[11] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      h[12+i] = 8'(SRC >> (24 - 8*i));
      h[16+i] = 8'(dst >> (24 - 8*i));
    end
    s = 32'd0;
    for (int i = 0; i < hl; i += 2) s = s + 32'({h[i], h[i+1]});
    while (s[31:16] != 16'd0) s = {16'd0, s[31:16]} + {16'd0, s[15:0]};
    h[10] = ~s[15:8];
    h[11] = ~s[7:0];
    frm.delete();
    for (int i = 0; i < hl; i++) frm.push_back(h[i]);
    for (int i = 0; i < plen; i++) frm.push_back(8'($urandom));
    for (int i = 0; i < npad; i++) frm.push_back(8'h00);
  endtask

  task automatic expect_good(input logic [31:0] dst, input int hl, input int plen, input int npush,
                             input logic [15:0] id);
    mexp_q.push_back('{SRC, dst, id, 16'(plen), 8'd17, 8'd64});
    for (int i = 0; i < npush; i++)
      exp_q.push_back('{frm[hl+i], 1'(i == 0), 1'(i == plen - 1)});
  endtask

  task automatic send(input int n, input bit eof, input bit ferr, input bit ipv4, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        in_val = 1'b0; in_dat = 8'($urandom); in_sof = 1'($urandom);
        in_eof = 1'($urandom); in_err = 1'($urandom);
      end
      @(posedge clk); #1;
      in_val = 1'b1; in_dat = frm[i]; in_sof = (i == 0);
      in_eof = eof && (i == n - 1); in_err = ferr && (i == n - 1); in_ipv4 = ipv4;
    end
    @(posedge clk); #1;
    in_val = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_err = 1'b0;
  endtask

  task automatic snap();
    b_meta = c_meta; b_val = c_val; b_eof = c_eof; b_err = c_err;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
    dm = c_meta - b_meta; dv = c_val - b_val; de = c_eof - b_eof; dr = c_err - b_err;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({out_dat, out_val, out_sof, out_eof, out_err, meta_val, busy} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got dat=%h val=%b sof=%b eof=%b err=%b mval=%b busy=%b want all 0",
               out_dat, out_val, out_sof, out_eof, out_err, meta_val, busy);
    end
    n_cmp++;
    if ({meta_src_ip, meta_dst_ip, meta_id, meta_pld_len, meta_proto, meta_ttl} !== 112'd0) begin
      n_bad++;
      $display("FAIL reset_meta got len=%0d dst=%h want 0", meta_pld_len, meta_dst_ip);
    end
  endtask

  task automatic test_udp_basic(input string nm, input bit gaps);
    build(DEV, 5, 8, 18, 16'h1234);
    expect_good(DEV, 20, 8, 8, 16'h1234);
    snap();
    send(46, 1'b1, 1'b0, 1'b1, gaps);
    drain();
    n_cmp++;
    if ({dm, dv, de, dr} !== {32'd1, 32'd8, 32'd1, 32'd0}) begin
      n_bad++;
      $display("FAIL %s_counts got meta=%0d val=%0d eof=%0d err=%0d want 1/8/1/0", nm, dm, dv, de, dr);
    end
    n_cmp++;
    if ((exp_q.size() + mexp_q.size()) !== 0) begin
      n_bad++;
      $display("FAIL %s_leftover got %0d pending want 0", nm, exp_q.size() + mexp_q.size());
    end
  endtask

  task automatic test_bad_cks();
    build(DEV, 5, 8, 18, 16'h2222);
    frm[11] = frm[11] ^ 8'h01;
    snap();
    send(46, 1'b1, 1'b0, 1'b1, 1'b0);
    drain();
    n_cmp++;
    if ({dm, dv, de, dr, 31'd0, busy} !== {32'd0, 32'd0, 32'd0, 32'd1, 32'd0}) begin
      n_bad++;
      $display("FAIL bad_cks got meta=%0d val=%0d eof=%0d err=%0d busy=%b want 0/0/0/1 busy 0",
               dm, dv, de, dr, busy);
    end
  endtask

  task automatic test_options();
    build(DEV, 6, 12, 10, 16'h0055);
    expect_good(DEV, 24, 12, 12, 16'h0055);
    snap();
    send(46, 1'b1, 1'b0, 1'b1, 1'b1);
    drain();
    n_cmp++;
    if ({dm, dv, de, dr} !== {32'd1, 32'd12, 32'd1, 32'd0}) begin
      n_bad++;
      $display("FAIL options_counts got meta=%0d val=%0d eof=%0d err=%0d want 1/12/1/0", dm, dv, de, dr);
    end
  endtask

  task automatic test_dst();
    build(32'hFFFF_FFFF, 5, 8, 4, 16'h0B0B);
    expect_good(32'hFFFF_FFFF, 20, 8, 8, 16'h0B0B);
    snap();
    send(32, 1'b1, 1'b0, 1'b1, 1'b0);
    drain();
    n_cmp++;
    if ({dm, dv, de, dr} !== {32'd1, 32'd8, 32'd1, 32'd0}) begin
      n_bad++;
      $display("FAIL bcast_counts got meta=%0d val=%0d eof=%0d err=%0d want 1/8/1/0", dm, dv, de, dr);
    end
    build(32'h0A00_0063, 5, 8, 4, 16'h0C0C);
    snap();
    send(32, 1'b1, 1'b0, 1'b1, 1'b0);
    drain();
    n_cmp++;
    if ({dm, dv, de, dr} !== {32'd0, 32'd0, 32'd0, 32'd1}) begin
      n_bad++;
      $display("FAIL wrong_dst_counts got meta=%0d val=%0d eof=%0d err=%0d want 0/0/0/1", dm, dv, de, dr);
    end
  endtask

  task automatic test_truncate();
    build(DEV, 5, 8, 0, 16'h0D0D);
    snap();
    send(10, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({out_err, busy, meta_val} !== 3'b100) begin
      n_bad++;
      $display("FAIL trunc_timing got err=%b busy=%b mval=%b want err=1 busy=0 mval=0",
               out_err, busy, meta_val);
    end
    drain();
    n_cmp++;
    if ({dm, dv, de, dr} !== {32'd0, 32'd0, 32'd0, 32'd1}) begin
      n_bad++;
      $display("FAIL trunc_counts got meta=%0d val=%0d eof=%0d err=%0d want 0/0/0/1", dm, dv, de, dr);
    end
    test_udp_basic("after_trunc", 1'b0);
  endtask

  task automatic test_zero_len();
    build(DEV, 5, 0, 6, 16'h0E0E);
    expect_good(DEV, 20, 0, 0, 16'h0E0E);
    snap();
    send(26, 1'b1, 1'b0, 1'b1, 1'b0);
    drain();
    n_cmp++;
    if ({dm, dv, de, dr} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL zero_len_counts got meta=%0d val=%0d eof=%0d err=%0d want 1/0/0/0", dm, dv, de, dr);
    end
  endtask

  task automatic test_fcs_after_eof();
    build(DEV, 5, 8, 10, 16'h0F0F);
    expect_good(DEV, 20, 8, 8, 16'h0F0F);
    snap();
    send(38, 1'b1, 1'b1, 1'b1, 1'b0);
    drain();
    n_cmp++;
    if ({dm, dv, de, dr} !== {32'd1, 32'd8, 32'd1, 32'd1}) begin
      n_bad++;
      $display("FAIL fcs_counts got meta=%0d val=%0d eof=%0d err=%0d want 1/8/1/1", dm, dv, de, dr);
    end
  endtask

  task automatic test_back_to_back();
    build(DEV, 5, 8, 4, 16'hA0A0);
    snap();
    send(15, 1'b0, 1'b0, 1'b1, 1'b0);
    build(DEV, 5, 8, 4, 16'hB0B0);
    expect_good(DEV, 20, 8, 8, 16'hB0B0);
    send(32, 1'b1, 1'b0, 1'b1, 1'b1);
    drain();
    n_cmp++;
    if ({dm, dv, de, dr} !== {32'd1, 32'd8, 32'd1, 32'd1}) begin
      n_bad++;
      $display("FAIL abort_counts got meta=%0d val=%0d eof=%0d err=%0d want 1/8/1/1", dm, dv, de, dr);
    end
    build(DEV, 5, 8, 4, 16'hC0C0);
    snap();
    send(32, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    n_cmp++;
    if ({dm, dv, de, dr, 31'd0, busy} !== {32'd0, 32'd0, 32'd0, 32'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL non_ipv4 got meta=%0d val=%0d eof=%0d err=%0d busy=%b want all 0",
               dm, dv, de, dr, busy);
    end
  endtask

  task automatic test_rst_mid();
    build(DEV, 5, 8, 18, 16'h3333);
    // reset lands as payload byte 2 is emitted, so only bytes 0 and 1 are ever sampled
    expect_good(DEV, 20, 8, 2, 16'h3333);
    snap();
    send(23, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_dat, out_val, out_sof, out_eof, out_err, meta_val, busy, meta_pld_len, meta_dst_ip} !== 62'd0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs got val=%b err=%b eof=%b mval=%b busy=%b len=%0d want all 0",
               out_val, out_err, out_eof, meta_val, busy, meta_pld_len);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drain();
    n_cmp++;
    if ({dm, dv, de, dr, exp_q.size()} !== {32'd1, 32'd2, 32'd0, 32'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL rst_mid_counts got meta=%0d val=%0d eof=%0d err=%0d pend=%0d want 1/2/0/0/0",
               dm, dv, de, dr, exp_q.size());
    end
    test_udp_basic("after_rst", 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    in_dat = 8'h00; in_val = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_ipv4 = 1'b0; in_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_udp_basic("basic", 1'b0);
    test_udp_basic("basic_gaps", 1'b1);
    test_bad_cks();
    test_options();
    test_dst();
    test_truncate();
    test_zero_len();
    test_fcs_after_eof();
    test_back_to_back();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
